// File: rtl/game_timer_ctrl.sv
// Game state sequencer for the survival-time score: IDLE/RUN/OVER FSM, seconds prescaler,
// saturating 3-digit BCD score and best-score tracking, all outputs registered.
module game_timer_ctrl #(
   parameter int unsigned CLK_HZ  = 50000000,
   parameter int unsigned TICK_HZ = 1
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start_key,
   input  logic       collided,
   output logic [3:0] score0,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic [3:0] best0,
   output logic [3:0] best1,
   output logic [3:0] best2,
   output logic [1:0] state,
   output logic       sec_tick,
   output logic       game_over
);

   localparam int unsigned Period   = CLK_HZ / TICK_HZ;
   localparam int unsigned CntWidth = (Period > 1) ? $clog2(Period) : 1;
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(Period - 1);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StOver = 2'b10
   } state_e;

   state_e              state_q;
   logic                start_q;
   logic [CntWidth-1:0] presc_q;

   logic                start_rise;
   logic                terminal;
   logic                score_max;
   logic                score_gt_best;
   logic [3:0]          inc0;
   logic [3:0]          inc1;
   logic [3:0]          inc2;

   assign start_rise = start_key & ~start_q;
   assign terminal   = (presc_q == CntLast);
   assign score_max  = (score2 == 4'd9) && (score1 == 4'd9) && (score0 == 4'd9);
   // Digits are valid BCD, so a plain packed compare orders them hundreds-first.
   assign score_gt_best = {score2, score1, score0} > {best2, best1, best0};
   assign state = state_q;

   // BCD +1 with units->tens->hundreds carry; only used when the score is below 999.
   always_comb begin
      inc0 = score0;
      inc1 = score1;
      inc2 = score2;
      if (score0 != 4'd9) begin
         inc0 = score0 + 4'd1;
      end else begin
         inc0 = 4'd0;
         if (score1 != 4'd9) begin
            inc1 = score1 + 4'd1;
         end else begin
            inc1 = 4'd0;
            inc2 = score2 + 4'd1;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q   <= StIdle;
         start_q   <= 1'b0;
         presc_q   <= '0;
         score0    <= 4'd0;
         score1    <= 4'd0;
         score2    <= 4'd0;
         best0     <= 4'd0;
         best1     <= 4'd0;
         best2     <= 4'd0;
         sec_tick  <= 1'b0;
         game_over <= 1'b0;
      end else begin
         start_q   <= start_key;
         sec_tick  <= 1'b0;
         game_over <= 1'b0;
         case (state_q)
            StIdle: begin
               score0 <= 4'd0;
               score1 <= 4'd0;
               score2 <= 4'd0;
               if (start_rise) begin
                  state_q <= StRun;
                  presc_q <= '0;
               end
            end
            StRun: begin
               if (collided) begin
                  // Collision wins over a coinciding terminal count.
                  state_q   <= StOver;
                  game_over <= 1'b1;
                  presc_q   <= '0;
                  if (score_gt_best) begin
                     best0 <= score0;
                     best1 <= score1;
                     best2 <= score2;
                  end
               end else if (terminal) begin
                  presc_q <= '0;
                  if (!score_max) begin
                     score0   <= inc0;
                     score1   <= inc1;
                     score2   <= inc2;
                     sec_tick <= 1'b1;
                  end
               end else begin
                  presc_q <= presc_q + 1'b1;
               end
            end
            StOver: begin
               presc_q <= '0;
               if (start_rise) begin
                  state_q <= StRun;
                  score0  <= 4'd0;
                  score1  <= 4'd0;
                  score2  <= 4'd0;
               end
            end
            default: begin
               state_q <= StIdle;
               presc_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: integer-score reference model compared every cycle, directed
// scenarios with literal expectations, then randomized start/collide/reset traffic.
module tb_game_timer_ctrl;

   localparam int P = 10;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic       start_key = 1'b0;
   logic       collided = 1'b0;
   logic [3:0] score0, score1, score2, best0, best1, best2;
   logic [1:0] state;
   logic       sec_tick, game_over;

   game_timer_ctrl #(
      .CLK_HZ (10),
      .TICK_HZ(1)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .start_key(start_key),
      .collided (collided),
      .score0   (score0),
      .score1   (score1),
      .score2   (score2),
      .best0    (best0),
      .best1    (best1),
      .best2    (best2),
      .state    (state),
      .sec_tick (sec_tick),
      .game_over(game_over)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Reference model: score and best kept as plain integers 0..999.
   int m_state = 0;
   int m_score = 0;
   int m_best = 0;
   int m_cnt = 0;
   int m_start_q = 0;
   int m_tick = 0;
   int m_go = 0;

   int n_tot = 0;
   int n_bad = 0;
   int cyc = 0;

   task automatic chk(input string name, input int got, input int exp);
      n_tot++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic int dig(input int v, input int d);
      return (d == 0) ? v % 10 : (d == 1) ? (v / 10) % 10 : v / 100;
   endfunction

   task automatic model_step(input logic r, input logic sk, input logic col);
      int rise;
      m_tick = 0;
      m_go = 0;
      if (r) begin
         m_state = 0; m_score = 0; m_best = 0; m_cnt = 0; m_start_q = 0;
      end else begin
         rise = (sk && m_start_q == 0) ? 1 : 0;
         m_start_q = sk ? 1 : 0;
         if (m_state == 0) begin
            if (rise == 1) begin m_state = 1; m_cnt = 0; end
         end else if (m_state == 1) begin
            if (col) begin
               m_state = 2; m_go = 1; m_cnt = 0;
               if (m_score > m_best) m_best = m_score;
            end else if (m_cnt == P - 1) begin
               m_cnt = 0;
               if (m_score < 999) begin m_score++; m_tick = 1; end
            end else begin
               m_cnt++;
            end
         end else begin
            m_cnt = 0;
            if (rise == 1) begin m_state = 1; m_score = 0; end
         end
      end
   endtask

   task automatic cycle(input logic r, input logic sk, input logic col);
      logic [27:0] got, exp;
      reset = r; start_key = sk; collided = col;
      @(posedge CLOCK_50);
      model_step(r, sk, col);
      cyc++;
      @(negedge CLOCK_50);
      got = {state, score2, score1, score0, best2, best1, best0, sec_tick, game_over};
      exp = {2'(m_state), 4'(dig(m_score, 2)), 4'(dig(m_score, 1)), 4'(dig(m_score, 0)),
             4'(dig(m_best, 2)), 4'(dig(m_best, 1)), 4'(dig(m_best, 0)),
             1'(m_tick), 1'(m_go)};
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL model_cmp cycle %0d: got st/sc/bs/tk/go=%h expected %h", cyc, got, exp);
      end
   endtask

   // Run until the model sits on the terminal-count cycle at the given score.
   task automatic run_to(input int target, input int limit);
      int n = 0;
      while (!(m_state == 1 && m_score == target && m_cnt == P - 1) && n < limit) begin
         cycle(1'b0, 1'b0, 1'b0);
         n++;
      end
      chk("run_to_bound", (n < limit) ? 1 : 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int ticks[$];
      int nt;
      int sk;

      // Reset state
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      chk("reset_state", int'(state), 0);
      chk("reset_score", int'({score2, score1, score0}), 0);
      chk("reset_best", int'({best2, best1, best0}), 0);
      cycle(1'b0, 1'b0, 1'b0);
      chk("idle_stays", int'(state), 0);

      // 1: one-cycle start pulse, 35 cycles of play
      cycle(1'b0, 1'b1, 1'b0);
      chk("t1_enter_run", int'(state), 1);
      for (int k = 1; k <= 35; k++) begin
         cycle(1'b0, 1'b0, 1'b0);
         if (sec_tick) ticks.push_back(k);
      end
      chk("t1_state", int'(state), 1);
      chk("t1_score", int'({score2, score1, score0}), 12'h003);
      chk("t1_ntick", ticks.size(), 3);
      if (ticks.size() == 3) begin
         chk("t1_tick0", ticks[0], 10);
         chk("t1_tick1", ticks[1], 20);
         chk("t1_tick2", ticks[2], 30);
      end

      // 2: collide on the terminal-count cycle at 007
      run_to(7, 200);
      cycle(1'b0, 1'b0, 1'b1);
      chk("t2_state", int'(state), 2);
      chk("t2_game_over", int'(game_over), 1);
      chk("t2_no_tick", int'(sec_tick), 0);
      chk("t2_score", int'({score2, score1, score0}), 12'h007);
      chk("t2_best", int'({best2, best1, best0}), 12'h007);
      cycle(1'b0, 1'b0, 1'b0);
      chk("t2_go_pulse", int'(game_over), 0);

      // 3: held start key restarts once; dying at 004 keeps best 007
      cycle(1'b0, 1'b1, 1'b0);
      chk("t3_restart", int'(state), 1);
      chk("t3_score0", int'({score2, score1, score0}), 0);
      chk("t3_best", int'({best2, best1, best0}), 12'h007);
      for (int k = 0; k < 19; k++) cycle(1'b0, 1'b1, 1'b0);
      chk("t3_still_run", int'(state), 1);
      run_to(3, 200);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      chk("t3_over", int'(state), 2);
      chk("t3_score4", int'({score2, score1, score0}), 12'h004);
      chk("t3_best_kept", int'({best2, best1, best0}), 12'h007);

      // 5: carries 009->010 and 099->100
      cycle(1'b0, 1'b1, 1'b0);
      run_to(9, 200);
      cycle(1'b0, 1'b0, 1'b0);
      chk("t5_carry10", int'({score2, score1, score0}), 12'h010);
      run_to(99, 2000);
      cycle(1'b0, 1'b0, 1'b0);
      chk("t5_carry100", int'({score2, score1, score0}), 12'h100);

      // 4: saturation at 999
      run_to(997, 10000);
      cycle(1'b0, 1'b0, 1'b0);
      chk("t4_at998", int'({score2, score1, score0}), 12'h998);
      nt = 0;
      for (int k = 0; k < 30; k++) begin
         cycle(1'b0, 1'b0, 1'b0);
         if (sec_tick) nt++;
      end
      chk("t4_sat_score", int'({score2, score1, score0}), 12'h999);
      chk("t4_one_tick", nt, 1);

      // 6: reset wins over start and collide in RUN
      chk("t6_pre_run", int'(state), 1);
      cycle(1'b1, 1'b1, 1'b1);
      chk("t6_state", int'(state), 0);
      chk("t6_score", int'({score2, score1, score0}), 0);
      chk("t6_best", int'({best2, best1, best0}), 0);
      chk("t6_go", int'(game_over), 0);

      // Randomized traffic
      sk = 0;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 5) == 0) sk = 1 - sk;
         cycle(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0, 1'(sk),
               ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
